bus_arbiter_n: RTL and testbench



---
 rtl/bus_arbiter_n.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter_n.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed or round-robin priority with an optional tenure limit.
// When no master owns the shared bus, the arbiter parks the bus at zero.
//
//   state | meaning
//   IDLE  | no grant; buses parked at 0 (a master that just expired may be masked out here)
//   OWNED | exactly one grant bit high; the owning master drives the buses
module bus_arbiter_n #(
    parameter int MASTERS        = 4,
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ROUND_ROBIN    = 1,
    parameter int MAX_TENURE     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [MASTERS-1:0]             req,
    output logic [MASTERS-1:0]             grant,
    output logic [$clog2(MASTERS)-1:0]     owner,
    output logic                           bus_busy,
    output logic [ADDR_BUS_WIDTH-1:0]      addr_bus,
    output logic [DATA_BUS_WIDTH-1:0]      data_bus,
    output logic                           wr_bus,
    output logic                           rd_bus,
    output logic                           fc_bus
);

    localparam int IW = $clog2(MASTERS);
    localparam int TW = $clog2(MAX_TENURE + 2);
    localparam logic [TW-1:0] TEN_LIM = (MAX_TENURE == 0) ? {TW{1'b1}} : TW'(MAX_TENURE);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t             state, state_n;
    logic [MASTERS-1:0] grant_q, grant_n;
    logic [IW-1:0]      owner_q, owner_n;
    logic [IW-1:0]      rr_ptr, rr_ptr_n;
    logic [TW-1:0]      tenure, tenure_n;
    logic               expired, expired_n;
    logic [IW-1:0]      exp_idx, exp_idx_n;

    logic [MASTERS-1:0] others;
    logic [MASTERS-1:0] masked;
    logic [MASTERS-1:0] elig;
    logic [IW-1:0]      start;
    logic [IW-1:0]      win;
    logic               do_grant;

    // First set bit of v, searching upward from start and wrapping.
    function automatic logic [IW-1:0] pick(input logic [MASTERS-1:0] v, input logic [IW-1:0] from);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            idx = int'(from) + i;
            if (idx >= MASTERS) idx = idx - MASTERS;
            if (!found && v[idx]) begin
                found = 1'b1;
                w     = IW'(idx);
            end
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_ptr  <= '0;
            tenure  <= '0;
            expired <= 1'b0;
            exp_idx <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            owner_q <= owner_n;
            rr_ptr  <= rr_ptr_n;
            tenure  <= tenure_n;
            expired <= expired_n;
            exp_idx <= exp_idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant_q;
        owner_n   = owner_q;
        rr_ptr_n  = rr_ptr;
        tenure_n  = tenure;
        expired_n = expired;
        exp_idx_n = exp_idx;
        others    = req & ~grant_q;
        masked    = req & ~(MASTERS'(1) << exp_idx);
        elig      = '0;
        do_grant  = 1'b0;
        start     = (ROUND_ROBIN != 0) ? rr_ptr : '0;

        case (state)
            S_IDLE: begin
                grant_n   = '0;
                owner_n   = '0;
                tenure_n  = '0;
                expired_n = 1'b0;
                // The expired master sits out only while someone else is still asking.
                if (expired && (masked != '0)) elig = masked;
                else                           elig = req;
                do_grant = (elig != '0);
            end
            S_OWNED: begin
                if (!req[owner_q]) begin
                    elig     = others;
                    do_grant = (others != '0);
                    if (!do_grant) begin
                        state_n  = S_IDLE;
                        grant_n  = '0;
                        owner_n  = '0;
                        tenure_n = '0;
                    end
                end else if ((MAX_TENURE != 0) && (tenure == TEN_LIM) && (others != '0)) begin
                    state_n   = S_IDLE;
                    grant_n   = '0;
                    owner_n   = '0;
                    tenure_n  = '0;
                    expired_n = 1'b1;
                    exp_idx_n = owner_q;
                end else if (tenure != TEN_LIM) begin
                    tenure_n = tenure + TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
                owner_n = '0;
            end
        endcase

        win = pick(elig, start);
        if (do_grant) begin
            state_n  = S_OWNED;
            grant_n  = MASTERS'(1) << win;
            owner_n  = win;
            rr_ptr_n = (int'(win) == MASTERS - 1) ? '0 : win + IW'(1);
            tenure_n = TW'(1);
        end
    end

    always_comb begin
        grant    = grant_q;
        owner    = owner_q;
        bus_busy = |grant_q;
    end

    // Parking depends only on registered state, so it can never overlap a grant cycle.
    assign addr_bus = bus_busy ? {ADDR_BUS_WIDTH{1'bz}} : {ADDR_BUS_WIDTH{1'b0}};
    assign data_bus = bus_busy ? {DATA_BUS_WIDTH{1'bz}} : {DATA_BUS_WIDTH{1'b0}};
    assign wr_bus   = bus_busy ? 1'bz : 1'b0;
    assign rd_bus   = bus_busy ? 1'bz : 1'b0;
    assign fc_bus   = bus_busy ? 1'bz : 1'b0;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: a round-robin and a fixed-priority instance,
// each with a tenure limit of 4, checked against queued expected grants.
module tb_bus_arbiter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_rr = '0;
    logic [3:0] req_fp = '0;

    logic [3:0]  grant_rr, grant_fp;
    logic [1:0]  owner_rr, owner_fp;
    logic        busy_rr, busy_fp;
    wire  [31:0] addr_rr, addr_fp;
    wire  [7:0]  data_rr, data_fp;
    wire         wr_rr, rd_rr, fc_rr, wr_fp, rd_fp, fc_fp;

    int total  = 0;
    int passed = 0;

    bit         q_dut[$];
    logic [3:0] q_grant[$];
    logic [1:0] q_owner[$];
    string      q_tag[$];

    always #5 clk = ~clk;

    bus_arbiter_n #(.MASTERS(4), .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(8),
                    .ROUND_ROBIN(1), .MAX_TENURE(4)) u_rr (
        .clk(clk), .rst(rst), .req(req_rr), .grant(grant_rr), .owner(owner_rr),
        .bus_busy(busy_rr), .addr_bus(addr_rr), .data_bus(data_rr),
        .wr_bus(wr_rr), .rd_bus(rd_rr), .fc_bus(fc_rr));

    bus_arbiter_n #(.MASTERS(4), .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(8),
                    .ROUND_ROBIN(0), .MAX_TENURE(4)) u_fp (
        .clk(clk), .rst(rst), .req(req_fp), .grant(grant_fp), .owner(owner_fp),
        .bus_busy(busy_fp), .addr_bus(addr_fp), .data_bus(data_fp),
        .wr_bus(wr_fp), .rd_bus(rd_fp), .fc_bus(fc_fp));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic expect_g(input bit dut, input logic [3:0] g, input logic [1:0] o, input string tag);
        q_dut.push_back(dut);
        q_grant.push_back(g);
        q_owner.push_back(o);
        q_tag.push_back(tag);
    endtask

    // Advance one edge, then pop every pending expectation against the post-edge outputs.
    task automatic tick();
        bit         d;
        logic [3:0] g;
        logic [1:0] o;
        string      t;
        logic [3:0] og;
        logic [1:0] oo;
        logic       ob;
        logic [42:0] park;
        @(posedge clk);
        #1;
        while (q_grant.size() > 0) begin
            d = q_dut.pop_front();
            g = q_grant.pop_front();
            o = q_owner.pop_front();
            t = q_tag.pop_front();
            og   = d ? grant_fp : grant_rr;
            oo   = d ? owner_fp : owner_rr;
            ob   = d ? busy_fp  : busy_rr;
            park = d ? {addr_fp, data_fp, wr_fp, rd_fp, fc_fp}
                     : {addr_rr, data_rr, wr_rr, rd_rr, fc_rr};
            chk({t, ".grant"}, 64'(og), 64'(g));
            chk({t, ".owner"}, 64'(oo), 64'(o));
            chk({t, ".busy"},  64'(ob), 64'(|g));
            if (g == 4'b0000) chk({t, ".park"}, 64'(park), 64'd0);
        end
    endtask

    task automatic rr_step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o, input string tag);
        req_rr = r;
        expect_g(1'b0, g, o, tag);
        tick();
    endtask

    task automatic fp_step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o, input string tag);
        req_fp = r;
        expect_g(1'b1, g, o, tag);
        tick();
    endtask

    task automatic reset_pulse(input string tag);
        rst    = 1'b1;
        req_rr = '0;
        req_fp = '0;
        expect_g(1'b0, 4'b0000, 2'd0, {tag, "_rr"});
        expect_g(1'b1, 4'b0000, 2'd0, {tag, "_fp"});
        tick();
        rst = 1'b0;
    endtask

    initial begin
        reset_pulse("reset0");
        reset_pulse("reset1");

        // single request, one-cycle latency, release parks the bus
        rr_step(4'b0100, 4'b0100, 2'd2, "t1_grant");
        rr_step(4'b0100, 4'b0100, 2'd2, "t1_hold");
        rr_step(4'b0000, 4'b0000, 2'd0, "t1_release");

        // round-robin rotation with direct handover
        reset_pulse("t2_reset");
        rr_step(4'b1111, 4'b0001, 2'd0, "t2_g0");
        rr_step(4'b1110, 4'b0010, 2'd1, "t2_g1");
        rr_step(4'b1101, 4'b0100, 2'd2, "t2_g2");
        rr_step(4'b1011, 4'b1000, 2'd3, "t2_g3");
        rr_step(4'b0111, 4'b0001, 2'd0, "t2_wrap0");
        rr_step(4'b0000, 4'b0000, 2'd0, "t2_idle");

        // fixed priority: master 0 wins whenever it asks, 3 only when 2:0 are quiet
        fp_step(4'b1111, 4'b0001, 2'd0, "t3_g0");
        fp_step(4'b1110, 4'b0010, 2'd1, "t3_g1");
        fp_step(4'b1101, 4'b0001, 2'd0, "t3_back0");
        fp_step(4'b1110, 4'b0010, 2'd1, "t3_again1");
        fp_step(4'b1000, 4'b1000, 2'd3, "t3_g3");
        fp_step(4'b1001, 4'b1000, 2'd3, "t3_no_preempt");
        fp_step(4'b0001, 4'b0001, 2'd0, "t3_handover0");
        fp_step(4'b0000, 4'b0000, 2'd0, "t3_idle");

        // tenure expiry: 4 grant cycles, one masked idle cycle, then the waiter
        reset_pulse("t4_reset");
        rr_step(4'b0010, 4'b0010, 2'd1, "t4_c1");
        rr_step(4'b0010, 4'b0010, 2'd1, "t4_c2");
        rr_step(4'b1010, 4'b0010, 2'd1, "t4_c3");
        rr_step(4'b1010, 4'b0010, 2'd1, "t4_c4");
        rr_step(4'b1010, 4'b0000, 2'd0, "t4_expire_idle");
        rr_step(4'b1010, 4'b1000, 2'd3, "t4_g3_c1");
        rr_step(4'b1010, 4'b1000, 2'd3, "t4_g3_c2");
        rr_step(4'b1010, 4'b1000, 2'd3, "t4_g3_c3");
        rr_step(4'b1010, 4'b1000, 2'd3, "t4_g3_c4");
        rr_step(4'b1010, 4'b0000, 2'd0, "t4_expire3_idle");
        rr_step(4'b1010, 4'b0010, 2'd1, "t4_back1");
        rr_step(4'b0000, 4'b0000, 2'd0, "t4_idle");

        // lone requester keeps the bus past the limit; counter must saturate, not wrap
        reset_pulse("t5_reset");
        for (int i = 0; i < 20; i++) rr_step(4'b0010, 4'b0010, 2'd1, $sformatf("t5_c%0d", i + 1));
        rr_step(4'b1010, 4'b0000, 2'd0, "t5_late_expire");
        rr_step(4'b0010, 4'b0010, 2'd1, "t5_regrant_alone");
        rr_step(4'b0000, 4'b0000, 2'd0, "t5_idle");

        // reset mid-tenure; round-robin restarts from master 0
        rr_step(4'b0010, 4'b0010, 2'd1, "t6_own1");
        rst = 1'b1;
        expect_g(1'b0, 4'b0000, 2'd0, "t6_rst_drop");
        tick();
        rst = 1'b0;
        rr_step(4'b1111, 4'b0001, 2'd0, "t6_restart0");
        rr_step(4'b0000, 4'b0000, 2'd0, "t6_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
